bf_program_loader: RTL

Upstream feeder of the BF machine's program memory. Accepts an ASCII byte stream over a valid/ready handshake, discards non-BF characters, encodes the eight BF commands into 4-bit opcodes, and writes them sequentially into program memory from address 0. On a 0x00 terminator it appends HALT and raises `done`, which drives the core's PMInputDone. Optionally checks bracket balance.

---
 rtl/bf_pkg.sv | 41 ++++
 rtl/bf_char_decode.sv | 28 ++
 rtl/bf_program_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared types and constants for the BF program loader and character decoder.
package bf_pkg;

  localparam int unsigned OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_HALT  = 4'd0,
    OP_INC   = 4'd1,
    OP_DEC   = 4'd2,
    OP_RIGHT = 4'd3,
    OP_LEFT  = 4'd4,
    OP_OUT   = 4'd5,
    OP_IN    = 4'd6,
    OP_JMPF  = 4'd7,
    OP_JMPB  = 4'd8
  } op_e;

  localparam logic [7:0] CH_INC   = 8'h2B;  // '+'
  localparam logic [7:0] CH_DEC   = 8'h2D;  // '-'
  localparam logic [7:0] CH_RIGHT = 8'h3E;  // '>'
  localparam logic [7:0] CH_LEFT  = 8'h3C;  // '<'
  localparam logic [7:0] CH_OUT   = 8'h2E;  // '.'
  localparam logic [7:0] CH_IN    = 8'h2C;  // ','
  localparam logic [7:0] CH_JMPF  = 8'h5B;  // '['
  localparam logic [7:0] CH_JMPB  = 8'h5D;  // ']'
  localparam logic [7:0] CH_TERM  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } ld_state_e;

  typedef struct packed {
    logic is_cmd;
    logic is_term;
    op_e  opcode;
  } dec_t;

endpackage

// File: rtl/bf_char_decode.sv
// Combinational ASCII-to-opcode classifier; also intended for the UART echo path.
module bf_char_decode
  import bf_pkg::*;
(
  input  logic [7:0] byte_in,
  output dec_t       dec_c
);

  always_comb begin
    dec_c = '{is_cmd: 1'b1, is_term: 1'b0, opcode: OP_HALT};
    case (byte_in)
      CH_INC:   dec_c.opcode = OP_INC;
      CH_DEC:   dec_c.opcode = OP_DEC;
      CH_RIGHT: dec_c.opcode = OP_RIGHT;
      CH_LEFT:  dec_c.opcode = OP_LEFT;
      CH_OUT:   dec_c.opcode = OP_OUT;
      CH_IN:    dec_c.opcode = OP_IN;
      CH_JMPF:  dec_c.opcode = OP_JMPF;
      CH_JMPB:  dec_c.opcode = OP_JMPB;
      CH_TERM: begin
        dec_c.is_cmd  = 1'b0;
        dec_c.is_term = 1'b1;
      end
      default:  dec_c.is_cmd = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// Streams ASCII BF source into program memory as opcodes, terminated by HALT.
// Define BF_BRACKET_CHECK_EN to abort loads with unbalanced brackets.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned DEPTH_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [OP_W-1:0]   pm_data,
  output logic              pm_we,
  output logic              done,
  output logic [ADDR_W-1:0] prog_len,
  output logic              error
);

  if (ADDR_W < 1 || OP_W < OPC_W || DEPTH_W < 1) begin : g_param_check
    $error("bf_program_loader: unsupported parameter set");
  end

  // Top address is kept free so HALT always fits.
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
  logic [OP_W-1:0]   pm_data_q, pm_data_d;
  logic              pm_we_q, pm_we_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              cmd_ok;
  logic              halt_ok;
  dec_t              dec_c;

`ifdef BF_BRACKET_CHECK_EN
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  logic [DEPTH_W-1:0] depth_q, depth_d;
`endif

  bf_char_decode u_decode (
    .byte_in (byte_in),
    .dec_c   (dec_c)
  );

  assign accept = byte_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pm_addr_d = pm_addr_q;
    pm_data_d = pm_data_q;
    pm_we_d   = 1'b0;
    cmd_ok    = 1'b1;
    halt_ok   = 1'b1;
`ifdef BF_BRACKET_CHECK_EN
    depth_d   = depth_q;
    cmd_ok    = !((dec_c.opcode == OP_JMPF) && (depth_q == DEPTH_MAX)) &&
                !((dec_c.opcode == OP_JMPB) && (depth_q == '0));
    halt_ok   = (depth_q == '0);
`endif

    case (state_q)
      ST_LOAD: begin
        if (accept && dec_c.is_term) begin
          if (halt_ok) begin
            pm_we_d   = 1'b1;
            pm_addr_d = len_q;
            pm_data_d = OP_W'(OP_HALT);
            state_d   = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (accept && dec_c.is_cmd) begin
          // Capacity check comes before any bracket or pointer update.
          if (len_q == LAST_ADDR || !cmd_ok) begin
            state_d = ST_ERROR;
          end else begin
            pm_we_d   = 1'b1;
            pm_addr_d = len_q;
            pm_data_d = OP_W'(dec_c.opcode);
            len_d     = len_q + ADDR_W'(1);
`ifdef BF_BRACKET_CHECK_EN
            if (dec_c.opcode == OP_JMPF) depth_d = depth_q + DEPTH_W'(1);
            if (dec_c.opcode == OP_JMPB) depth_d = depth_q - DEPTH_W'(1);
`endif
          end
        end
      end
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD;
          len_d   = '0;
`ifdef BF_BRACKET_CHECK_EN
          depth_d = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_LOAD);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      pm_addr_q <= '0;
      pm_data_q <= '0;
      pm_we_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pm_addr_q <= pm_addr_d;
      pm_data_q <= pm_data_d;
      pm_we_q   <= pm_we_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ready_q   <= ready_d;
    end
  end

`ifdef BF_BRACKET_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) depth_q <= '0;
    else        depth_q <= depth_d;
  end
`endif

  assign byte_ready = ready_q;
  assign pm_addr    = pm_addr_q;
  assign pm_data    = pm_data_q;
  assign pm_we      = pm_we_q;
  assign done       = done_q;
  assign prog_len   = len_q;
  assign error      = error_q;

endmodule
